bus_mem_responder: RTL and testbench

Bus-side memory target that answers the single-outstanding read/write requests issued by the CPU memory controller. It latches one request, holds `bus_full` high while the access is in flight, and performs the access after a fixed latency. It then returns read data with a one-cycle valid pulse. It sits between the bus manager and a word-addressed RAM, and it is the data source for the controller's `data_in_BUS`/`bus_full` inputs.

---
 rtl/bus_pkg.sv | 26 ++
 rtl/word_ram.sv | 22 ++
 rtl/bus_mem_responder.sv | 99 +++++++++
 tb/tb_bus_mem_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus-target types: responder FSM states, request op, error data value.
// Also holds the request legality check applied to a latched request.
package bus_pkg;

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_BUSY,
    RSP_RESPOND
  } rsp_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } rsp_op_t;

  localparam logic [31:0] BUS_ERR_DATA = 32'h0;

  // Rejects conflicting strobes, non-word-aligned and out-of-array addresses.
  function automatic logic req_error(input logic both, input logic [31:0] addr,
                                     input int unsigned depth);
    logic [63:0] limit;
    limit = 64'(depth) << 2;
    return both | (addr[1:0] != 2'b00) | ({32'h0, addr} >= limit);
  endfunction

endpackage

// File: rtl/word_ram.sv
// Single-port DEPTH x 32 RAM; write and registered read take effect at the clock edge.
// No backpressure; rdata holds its value until the next read enable.
module word_ram #(
  parameter int DEPTH = 256,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [IW-1:0] index,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[index] <= wdata;
    if (re) rdata <= mem[index];
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Single-outstanding bus memory target; access commits LATENCY cycles after acceptance, then one respond cycle.
// Requests are dropped (not queued) while bus_full is high.
module bus_mem_responder
  import bus_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        read_i,
  input  logic        write_i,
  output logic        bus_full,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        error_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  rsp_state_t  state;
  logic [CW-1:0] cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  rsp_op_t     op_q;
  logic        both_q;
  logic        rdata_zero_q;
  logic [31:0] ram_rdata;
  logic        commit;
  logic        req_err;
  logic        ram_we;
  logic        ram_re;

  assign req_err  = req_error(both_q, addr_q, DEPTH);
  assign commit   = (state == RSP_BUSY) && (cnt == '0);
  assign ram_we   = commit && (op_q == OP_WRITE) && !req_err;
  assign ram_re   = commit && (op_q == OP_READ) && !req_err;
  assign bus_full = (state != RSP_IDLE);
  // RAM output register is not reset, so reset and read errors are shown as zero via a flag.
  assign rdata_o  = rdata_zero_q ? BUS_ERR_DATA : ram_rdata;

  word_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .index (addr_q[IW+1:2]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RSP_IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_q         <= OP_READ;
      both_q       <= 1'b0;
      rvalid_o     <= 1'b0;
      error_o      <= 1'b0;
      rdata_zero_q <= 1'b1;
    end else begin
      rvalid_o <= 1'b0;
      error_o  <= 1'b0;
      case (state)
        RSP_IDLE: begin
          if (read_i || write_i) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            op_q    <= read_i ? OP_READ : OP_WRITE;
            both_q  <= read_i & write_i;
            cnt     <= CW'(LATENCY - 1);
            state   <= RSP_BUSY;
          end
        end
        RSP_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= RSP_RESPOND;
            if (req_err) begin
              error_o <= 1'b1;
              if (op_q == OP_READ) rdata_zero_q <= 1'b1;
            end else if (op_q == OP_READ) begin
              rvalid_o     <= 1'b1;
              rdata_zero_q <= 1'b0;
            end
          end
        end
        RSP_RESPOND: state <= RSP_IDLE;
        default:     state <= RSP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: LATENCY=2 main instance plus a LATENCY=1 instance.
module tb_bus_mem_responder;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    bit          chk;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [31:0] addr_i = '0, wdata_i = '0;
  logic        read_i = 1'b0, write_i = 1'b0;
  logic        bus_full, rvalid_o, error_o;
  logic [31:0] rdata_o;

  logic [31:0] addr1 = '0, wdata1 = '0;
  logic        read1 = 1'b0, write1 = 1'b0;
  logic        bus_full1, rvalid1, error1;
  logic [31:0] rdata1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  bus_mem_responder #(.DEPTH(256), .LATENCY(LAT0)) u_dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .wdata_i(wdata_i), .read_i(read_i),
    .write_i(write_i), .bus_full(bus_full), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .error_o(error_o)
  );

  bus_mem_responder #(.DEPTH(256), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst(rst), .addr_i(addr1), .wdata_i(wdata1), .read_i(read1),
    .write_i(write1), .bus_full(bus_full1), .rdata_o(rdata1), .rvalid_o(rvalid1),
    .error_o(error1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop an expectation for every response pulse the DUTs present.
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid_o && error_o) check("dut0_pulse_exclusive", 32'd1, 32'd0);
      if (rvalid_o || error_o) begin
        if (q0.size() == 0) begin
          check("dut0_unexpected_pulse", {error_o, rvalid_o}, 32'd0);
        end else begin
          e0 = q0.pop_front();
          check("dut0_kind_error", {31'b0, error_o}, {31'b0, e0.is_err});
          check("dut0_pulse_cycle", cyc, e0.cyc);
          if (e0.chk) check("dut0_rdata", rdata_o, e0.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid1 && error1) check("dut1_pulse_exclusive", 32'd1, 32'd0);
      if (rvalid1 || error1) begin
        if (q1.size() == 0) begin
          check("dut1_unexpected_pulse", {error1, rvalid1}, 32'd0);
        end else begin
          e1 = q1.pop_front();
          check("dut1_kind_error", {31'b0, error1}, {31'b0, e1.is_err});
          check("dut1_pulse_cycle", cyc, e1.cyc);
          if (e1.chk) check("dut1_rdata", rdata1, e1.data);
        end
      end
    end
  end

  // One request on the LATENCY=2 instance; also checks how long bus_full stays high.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input bit rd, input bit wr,
                       input bit exp_err, input logic [31:0] exp_d, input bit chk);
    int n;
    int busy;
    exp_t e;
    @(negedge clk);
    check("idle_before_request", {31'b0, bus_full}, 32'd0);
    addr_i = a; wdata_i = d; read_i = rd; write_i = wr;
    @(posedge clk);
    #1;
    n = cyc;
    read_i = 1'b0; write_i = 1'b0;
    if (rd || exp_err) begin
      e = '{is_err: exp_err, data: exp_d, chk: chk, cyc: n + LAT0};
      q0.push_back(e);
    end
    busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_full) busy++;
    end
    check("bus_full_cycles", busy, LAT0 + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    exp_t e;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_bus_full", {31'b0, bus_full}, 32'd0);
    check("reset_rdata", rdata_o, 32'd0);
    check("reset_rvalid", {31'b0, rvalid_o}, 32'd0);
    check("reset_error", {31'b0, error_o}, 32'd0);
    rst = 1'b0;

    // Write then read back; misaligned and out-of-range reads; memory untouched
    issue(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1);
    issue(32'h13, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
    issue(32'h400, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
    issue(32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1);

    // Both strobes high is rejected and leaves memory alone
    issue(32'h20, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(32'h20, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
    issue(32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h12345678, 1'b1);

    // Requests held through BUSY and RESPOND are ignored
    @(negedge clk);
    check("ignore_idle_before", {31'b0, bus_full}, 32'd0);
    addr_i = 32'h10; read_i = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    e = '{is_err: 1'b0, data: 32'hDEADBEEF, chk: 1'b1, cyc: n + LAT0};
    q0.push_back(e);
    addr_i = 32'h20;
    repeat (3) @(posedge clk);
    #1;
    read_i = 1'b0;
    @(negedge clk);
    check("ignore_idle_after", {31'b0, bus_full}, 32'd0);
    @(negedge clk);
    check("ignore_not_accepted", {31'b0, bus_full}, 32'd0);
    repeat (4) @(negedge clk);

    // Reset during BUSY of a write drops it
    issue(32'h40, 32'h11112222, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    addr_i = 32'h40; wdata_i = 32'hCAFEF00D; write_i = 1'b1;
    @(posedge clk);
    #1;
    write_i = 1'b0;
    @(negedge clk);
    check("midop_busy", {31'b0, bus_full}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midop_rst_bus_full", {31'b0, bus_full}, 32'd0);
    check("midop_rst_rdata", rdata_o, 32'd0);
    check("midop_rst_rvalid", {31'b0, rvalid_o}, 32'd0);
    check("midop_rst_error", {31'b0, error_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    issue(32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 32'h11112222, 1'b1);

    // LATENCY=1: back-to-back reads with read held high accept every 3 cycles
    @(negedge clk);
    addr1 = 32'h8; wdata1 = 32'hA5A50001; write1 = 1'b1;
    @(posedge clk);
    #1;
    write1 = 1'b0;
    repeat (4) @(negedge clk);
    check("lat1_idle", {31'b0, bus_full1}, 32'd0);
    read1 = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    for (int k = 0; k < 3; k++) begin
      e = '{is_err: 1'b0, data: 32'hA5A50001, chk: 1'b1, cyc: n + 3 * k + LAT1};
      q1.push_back(e);
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("lat1_bus_full_pattern", {31'b0, bus_full1}, ((j % 3) != 2) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    read1 = 1'b0;
    repeat (4) @(negedge clk);
    check("lat1_stops_after_release", {31'b0, bus_full1}, 32'd0);

    repeat (3) @(negedge clk);
    check("dut0_all_responses_seen", q0.size(), 32'd0);
    check("dut1_all_responses_seen", q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
